// File: rtl/ntt_coeff_loader.sv
// ntt_coeff_loader: assembles streamed coefficients into one frame for the bit-reversal stage.
// A frame ends on s_last or on beat SIZE; slots that never receive a beat stay zero.
module ntt_coeff_loader #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        s_data,
    input  logic                    s_valid,
    input  logic                    s_last,
    output logic                    s_ready,
    input  logic [7:0]              s_perm,
    output logic [SIZE*WIDTH-1:0]   list_data,
    output logic [7:0]              list_perm,
    output logic                    list_valid,
    input  logic                    list_ready,
    output logic                    err_short,
    output logic                    err_long
);
    localparam int CW = $clog2(SIZE) + 1;

    typedef enum logic {COLLECT, HOLD} state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [SIZE*WIDTH-1:0]   data_q, data_d;
    logic [7:0]              perm_q, perm_d;
    logic                    err_short_q, err_short_d;
    logic                    err_long_q, err_long_d;
    logic                    beat, at_end;

    assign s_ready    = state_q == COLLECT;
    assign beat       = s_valid && s_ready;
    assign at_end     = cnt_q == CW'(SIZE - 1);
    assign list_data  = data_q;
    assign list_perm  = perm_q;
    assign list_valid = state_q == HOLD;
    assign err_short  = err_short_q;
    assign err_long   = err_long_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        perm_d      = perm_q;
        err_short_d = 1'b0;
        err_long_d  = 1'b0;
        if (beat) begin
            for (int i = 0; i < SIZE; i++)
                if (cnt_q == CW'(i)) data_d[i*WIDTH +: WIDTH] = s_data;
            cnt_d       = cnt_q + 1'b1;
            perm_d      = (cnt_q == '0) ? s_perm : perm_q;
            state_d     = (at_end || s_last) ? HOLD : COLLECT;
            err_short_d = s_last && !at_end;
            err_long_d  = at_end && !s_last;
        end else if (state_q == HOLD && list_ready) begin
            // clearing here is what zero-pads the next short frame
            state_d = COLLECT;
            cnt_d   = '0;
            data_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            cnt_q       <= '0;
            data_q      <= '0;
            perm_q      <= '0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            perm_q      <= perm_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
        end
    end
endmodule

// File: tb/tb_ntt_coeff_loader.sv
// tb_ntt_coeff_loader: drives directed and random frames and compares every cycle
// against a queue-based frame model.
module tb_ntt_coeff_loader;
    localparam int W = 32;
    localparam int S = 256;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [W-1:0]     s_data = '0;
    logic             s_valid = 1'b0;
    logic             s_last = 1'b0;
    logic             s_ready;
    logic [7:0]       s_perm = '0;
    logic [S*W-1:0]   list_data;
    logic [7:0]       list_perm;
    logic             list_valid;
    logic             list_ready = 1'b0;
    logic             err_short;
    logic             err_long;

    ntt_coeff_loader #(.WIDTH(W), .SIZE(S)) dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .s_perm(s_perm), .list_data(list_data), .list_perm(list_perm),
        .list_valid(list_valid), .list_ready(list_ready), .err_short(err_short), .err_long(err_long)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // model: accepted words of the current frame plus whether it is being presented
    logic [W-1:0] m_words[$];
    bit           m_hold, m_beat, m_es, m_el, m_zero;
    logic [7:0]   m_perm;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        m_beat = 0; m_es = 0; m_el = 0; m_zero = 0;
        if (!m_hold) begin
            if (s_valid) begin
                m_beat = 1;
                if (m_words.size() == 0) m_perm = s_perm;
                m_words.push_back(s_data);
                if (m_words.size() == S || s_last) begin
                    m_hold = 1;
                    m_es = s_last && m_words.size() < S;
                    m_el = m_words.size() == S && !s_last;
                end
            end
        end else if (list_ready) begin
            m_hold = 0;
            m_words.delete();
            m_zero = 1;
        end
    endtask

    task automatic check_outs();
        check("s_ready", s_ready, !m_hold);
        check("list_valid", list_valid, m_hold);
        check("err_short", err_short, m_es);
        check("err_long", err_long, m_el);
        check("list_perm", list_perm, m_perm);
        if (m_hold || m_zero)
            for (int k = 0; k < S; k++)
                check($sformatf("word%0d", k), list_data[k*W +: W],
                      k < m_words.size() ? m_words[k] : '0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outs();
    endtask

    task automatic do_reset();
        s_valid = 0; s_last = 0; list_ready = 0;
        rst_n = 0;
        #2;
        m_hold = 0; m_words.delete(); m_perm = '0; m_es = 0; m_el = 0; m_zero = 1;
        check_outs();
        @(negedge clk);
        rst_n = 1;
    endtask

    // mode: 0 -> k+1 with perm 0x5A, 1 -> all ones, 2 -> random; bubble: 0 none, 1 toggle, 2 random
    task automatic frame(int n, int last_at, int mode, int bubble, int hold_cyc, bit push_extra);
        int k = 0;
        int cyc = 0;
        while (k < n && cyc < 4 * S + 16) begin
            s_valid    = bubble == 0 ? 1'b1 : bubble == 1 ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            s_data     = mode == 0 ? W'(k + 1) : mode == 1 ? '1 : W'($urandom);
            s_last     = k == last_at;
            s_perm     = mode == 0 ? 8'h5A : 8'($urandom);
            list_ready = 1'($urandom_range(0, 1));
            step();
            cyc++;
            if (m_beat) k++;
        end
        if (k < n) check("beat_budget", k, n);
        s_valid = push_extra; s_last = 0; s_data = W'($urandom);
        if (m_hold) begin
            list_ready = 0;
            for (int i = 0; i < hold_cyc; i++) step();
            list_ready = 1;
            cyc = 0;
            while (m_hold && cyc < 4) begin step(); cyc++; end
            if (m_hold) check("handshake_budget", cyc, 0);
        end
        s_valid = 0; list_ready = 0;
        step();
    endtask

    initial begin
        #1;
        do_reset();
        frame(S, S - 1, 0, 0, 0, 0);
        frame(S, S - 1, 2, 0, 10, 0);
        frame(10, 9, 1, 0, 0, 0);
        frame(S, -1, 2, 0, 3, 1);
        frame(S, S - 1, 0, 1, 0, 0);
        frame(100, -1, 2, 0, 0, 0);
        do_reset();
        frame(S, S - 1, 2, 0, 0, 0);
        for (int f = 0; f < 8; f++) begin
            int n, la;
            n  = $urandom_range(1, S);
            la = n < S ? n - 1 : ($urandom_range(0, 1) ? S - 1 : -1);
            frame(n, la, 2, 2, $urandom_range(0, 5), 1'($urandom_range(0, 1)));
        end
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
